mem_burst_master: RTL and testbench



---
 rtl/mem_burst_master_if.sv | 29 ++
 rtl/mem_burst_master.sv | 115 +++++++++++
 tb/tb_mem_burst_master.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_burst_master_if.sv
// Core-facing command/payload streams plus bus strobe and address of the burst master.
// The bidirectional bus data lives outside the interface as a plain inout on the master.
interface mem_burst_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_base;
    logic [6:0]  req_len;
    logic        wdata_valid;
    logic        wdata_ready;
    logic [31:0] wdata;
    logic        rdata_valid;
    logic        rdata_ready;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic        mem_we;
    logic [31:0] mem_addr;

    modport master (
        input  req_valid, req_write, req_base, req_len, wdata_valid, wdata, rdata_ready,
        output req_ready, wdata_ready, rdata_valid, rdata, busy, done, mem_we, mem_addr
    );

    modport slave (
        output req_valid, req_write, req_base, req_len, wdata_valid, wdata, rdata_ready,
        input  req_ready, wdata_ready, rdata_valid, rdata, busy, done, mem_we, mem_addr
    );
endinterface

// File: rtl/mem_burst_master.sv
// Burst initiator on the shared single-word memory bus; MEM_BURST_TURNAROUND_EN adds a bus-idle TURN cycle after writes.
// Latency: one word per cycle; read data registered one cycle after its address; done one cycle after the last beat (two with TURN).
// Backpressure: wdata_valid low stalls the write burst; rdata_ready low holds the one-entry read register and the address.
module mem_burst_master #(
    parameter int MAX_LEN = 64
) (
    input  logic               clk,
    input  logic               rst,
    mem_burst_master_if.master bus,
    inout  wire  [31:0]        mem_data
);

`ifdef MEM_BURST_TURNAROUND_EN
    typedef enum logic [2:0] {IDLE, WR, RD, DRAIN, TURN} state_t;
`else
    typedef enum logic [1:0] {IDLE, WR, RD, DRAIN} state_t;
`endif

    state_t      state;
    state_t      state_nxt;
    logic [31:0] addr;
    logic [6:0]  cnt;
    logic [31:0] rdata_q;
    logic        rdata_valid_q;
    logic        done_q;
    logic [6:0]  len_eff;
    logic        accept;
    logic        wr_beat;
    logic        rd_take;
    logic        rd_pop;
    logic        last;
    logic        done_set;
    logic        unused_base;

    assign unused_base = ^bus.req_base[1:0];

    // Over-long requests are clamped rather than allowed to run past MAX_LEN.
    assign len_eff = (bus.req_len > 7'(MAX_LEN)) ? 7'(MAX_LEN) : bus.req_len;
    assign accept  = bus.req_valid && (state == IDLE);
    assign wr_beat = (state == WR) && bus.wdata_valid;
    assign rd_pop  = rdata_valid_q && bus.rdata_ready;
    assign rd_take = (state == RD) && (!rdata_valid_q || bus.rdata_ready);
    assign last    = (cnt == 7'd1);

    always_comb begin
        done_set = (accept && (len_eff == 7'd0)) || ((state == DRAIN) && rd_pop);
`ifdef MEM_BURST_TURNAROUND_EN
        done_set = done_set || (state == TURN);
`else
        done_set = done_set || (wr_beat && last);
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && (len_eff != 7'd0)) state_nxt = bus.req_write ? WR : RD;
`ifdef MEM_BURST_TURNAROUND_EN
            WR:      if (wr_beat && last) state_nxt = TURN;
            TURN:    state_nxt = IDLE;
`else
            WR:      if (wr_beat && last) state_nxt = IDLE;
`endif
            RD:      if (rd_take && last) state_nxt = DRAIN;
            DRAIN:   if (rd_pop) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready   = (state == IDLE);
        bus.busy        = (state != IDLE);
        bus.wdata_ready = (state == WR);
        bus.mem_we      = wr_beat;
    end

    assign bus.rdata_valid = rdata_valid_q;
    assign bus.rdata       = rdata_q;
    assign bus.done        = done_q;
    assign bus.mem_addr    = addr;

    // Responders only drive the bus while the strobe is low, so the two never overlap.
    assign mem_data = bus.mem_we ? bus.wdata : 32'hzzzz_zzzz;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr          <= 32'd0;
            cnt           <= 7'd0;
            rdata_q       <= 32'd0;
            rdata_valid_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            done_q <= done_set;
            if (accept) begin
                addr <= {bus.req_base[31:2], 2'b00};
                cnt  <= len_eff;
            end else if (wr_beat || rd_take) begin
                addr <= addr + 32'd4;
                cnt  <= cnt - 7'd1;
            end
            if (rd_take) begin
                rdata_q       <= mem_data;
                rdata_valid_q <= 1'b1;
            end else if (rd_pop) begin
                rdata_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_burst_master.sv
// Randomised burst traffic against a word-level memory model and address/data scoreboards.
module tb_mem_burst_master;

`ifdef MEM_BURST_TURNAROUND_EN
    localparam int WR_DONE_LAT = 1;
`else
    localparam int WR_DONE_LAT = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_burst_master_if bif();
    wire  [31:0] mem_data;

    mem_burst_master #(.MAX_LEN(64)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bif.master),
        .mem_data (mem_data)
    );

    // Bus responder: combinational read answer, commit on the strobe edge.
    logic [31:0] bus_mem [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic [31:0] rsp_val;
    assign rsp_val  = bus_mem[bif.mem_addr[11:2]];
    assign mem_data = bif.mem_we ? 32'hzzzz_zzzz : rsp_val;
    always @(posedge clk) if (bif.mem_we) bus_mem[bif.mem_addr[11:2]] <= mem_data;

    int n_chk  = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int we_cnt = 0;
    logic [31:0] exp_waddr[$];
    logic [31:0] exp_wdata[$];
    logic [31:0] exp_rdata[$];
    logic [31:0] we_log[$];
    logic [31:0] got_q[$];
    logic [31:0] wq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic summary();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (bif.mem_we) begin
                if (exp_waddr.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_write: got addr %h expected no write", bif.mem_addr);
                end else begin
                    chk("wr_addr", bif.mem_addr, exp_waddr.pop_front());
                    chk("wr_data", mem_data, exp_wdata.pop_front());
                end
                we_cnt++;
                we_log.push_back(bif.mem_addr);
            end else begin
                chk("bus_release", mem_data, rsp_val);
            end
            if (bif.rdata_valid && bif.rdata_ready) begin
                if (exp_rdata.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_rdata: got %h expected none", bif.rdata);
                end else begin
                    chk("rdata", bif.rdata, exp_rdata.pop_front());
                end
                got_q.push_back(bif.rdata);
            end
            if (bif.done) done_cnt++;
        end
    end

    initial begin
        #2ms;
        n_chk++; n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        summary();
        $finish;
    end

    task automatic issue_req(input logic w, input logic [31:0] base, input int len);
        int k;
        k = 0;
        bif.req_valid = 1'b1;
        bif.req_write = w;
        bif.req_base  = base;
        bif.req_len   = 7'(len);
        while (!bif.req_ready && k < 1000) begin @(negedge clk); k++; end
        if (k >= 1000) begin
            n_chk++; n_fail++;
            $display("FAIL req_timeout: got no req_ready expected accept");
        end
        @(negedge clk);
        bif.req_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_lat, input int dc0);
        int k;
        k = 0;
        while (!bif.done && k < 50) begin @(negedge clk); k++; end
        chk(name, k, exp_lat);
        repeat (2) @(negedge clk);
        chk("done_once", done_cnt, dc0 + 1);
        chk("busy_after", bif.busy, 1'b0);
    endtask

    task automatic wr_burst(input logic [31:0] base, input int len, input int stall_pct, input int abort_after);
        logic [31:0] a;
        int i, k, dc0;
        a = {base[31:2], 2'b00};
        for (int j = 0; j < len; j++) begin
            exp_waddr.push_back(a);
            exp_wdata.push_back(wq[j]);
            if (abort_after == 0 || j < abort_after) ref_mem[a[11:2]] = wq[j];
            a = a + 32'd4;
        end
        dc0 = done_cnt;
        issue_req(1'b1, base, len);
        if (len > 0) chk("busy_wr", bif.busy, 1'b1);
        i = 0; k = 0;
        while (i < len && k < 5000) begin
            if (abort_after != 0 && i == abort_after) break;
            bif.wdata_valid = ($urandom_range(0, 99) >= stall_pct);
            bif.wdata       = wq[i];
            if (bif.wdata_valid && bif.wdata_ready) i++;
            @(negedge clk);
            k++;
        end
        if (k >= 5000) begin
            n_chk++; n_fail++;
            $display("FAIL wr_timeout: got %0d beats expected %0d", i, len);
        end
        if (abort_after != 0) begin
            bif.wdata_valid = 1'b1;
            bif.wdata       = wq[i];
            rst = 1'b0;
            #1;
            chk("abort_we", bif.mem_we, 1'b0);
            chk("abort_busy", bif.busy, 1'b0);
            chk("abort_rdv", bif.rdata_valid, 1'b0);
            repeat (3) @(negedge clk);
            bif.wdata_valid = 1'b0;
            rst = 1'b1;
            exp_waddr.delete();
            exp_wdata.delete();
            repeat (2) @(negedge clk);
            chk("abort_no_done", done_cnt, dc0);
            chk("abort_req_ready", bif.req_ready, 1'b1);
        end else begin
            bif.wdata_valid = 1'b0;
            wait_done("wr_done_lat", (len > 0) ? WR_DONE_LAT : 0, dc0);
            chk("wr_q_empty", exp_waddr.size(), 0);
        end
        wq.delete();
    endtask

    task automatic rd_burst(input logic [31:0] base, input int len, input int rdy_pct,
                            input logic [31:0] stall_addr, input logic [31:0] chk_addr0);
        logic [31:0] a;
        int got, k, dc0;
        logic stalled;
        a = {base[31:2], 2'b00};
        for (int j = 0; j < len; j++) begin
            exp_rdata.push_back(ref_mem[a[11:2]]);
            a = a + 32'd4;
        end
        got_q.delete();
        dc0 = done_cnt;
        issue_req(1'b0, base, len);
        if (len > 0) chk("busy_rd", bif.busy, 1'b1);
        if (chk_addr0 != 32'd0) chk("rd_addr0", bif.mem_addr, chk_addr0);
        got = 0; k = 0; stalled = 1'b0;
        while (got < len && k < 5000) begin
            if (stall_addr != 32'd0 && got == 0 && bif.rdata_valid && !stalled) begin
                bif.rdata_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    chk("stall_addr", bif.mem_addr, stall_addr);
                    chk("stall_rdv", bif.rdata_valid, 1'b1);
                    @(negedge clk);
                end
                stalled = 1'b1;
                k += 5;
            end
            bif.rdata_ready = ($urandom_range(0, 99) < rdy_pct);
            if (bif.rdata_valid && bif.rdata_ready) got++;
            @(negedge clk);
            k++;
        end
        bif.rdata_ready = 1'b0;
        if (k >= 5000) begin
            n_chk++; n_fail++;
            $display("FAIL rd_timeout: got %0d words expected %0d", got, len);
        end
        wait_done("rd_done_lat", 0, dc0);
        chk("rd_q_empty", exp_rdata.size(), 0);
    endtask

    initial begin
        int wc0;
        logic [31:0] base;
        int len;
        for (int i = 0; i < 1024; i++) begin
            bus_mem[i] = (i >= 64 && i < 72) ? (32'd1 << (i - 64)) : 32'd0;
            ref_mem[i] = bus_mem[i];
        end
        bif.req_valid   = 1'b0;
        bif.req_write   = 1'b0;
        bif.req_base    = 32'd0;
        bif.req_len     = 7'd0;
        bif.wdata_valid = 1'b0;
        bif.wdata       = 32'd0;
        bif.rdata_ready = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", bif.req_ready, 1'b1);
        chk("rst_busy", bif.busy, 1'b0);
        chk("rst_done", bif.done, 1'b0);
        chk("rst_mem_we", bif.mem_we, 1'b0);
        chk("rst_mem_addr", bif.mem_addr, 32'd0);
        chk("rst_rdata_valid", bif.rdata_valid, 1'b0);
        chk("rst_rdata", bif.rdata, 32'd0);
        chk("rst_wdata_ready", bif.wdata_ready, 1'b0);
        rst = 1'b1;
        @(negedge clk);

        // Three-word write then readback
        wq = '{32'h11, 32'h22, 32'h33};
        we_log.delete(); wc0 = we_cnt;
        wr_burst(32'hffffc004, 3, 0, 0);
        chk("wr3_we_cycles", we_cnt - wc0, 3);
        chk("wr3_addr0", we_log[0], 32'hffffc004);
        chk("wr3_addr1", we_log[1], 32'hffffc008);
        chk("wr3_addr2", we_log[2], 32'hffffc00c);
        rd_burst(32'hffffc004, 3, 100, 32'd0, 32'd0);
        chk("rb_w0", got_q[0], 32'h11);
        chk("rb_w1", got_q[1], 32'h22);
        chk("rb_w2", got_q[2], 32'h33);

        rd_burst(32'hffffc100, 4, 100, 32'd0, 32'd0);
        chk("rd4_w0", got_q[0], 32'h1);
        chk("rd4_w1", got_q[1], 32'h2);
        chk("rd4_w2", got_q[2], 32'h4);
        chk("rd4_w3", got_q[3], 32'h8);

        rd_burst(32'hffffc100, 3, 100, 32'hffffc104, 32'd0);
        chk("stall_cnt", got_q.size(), 3);
        chk("stall_w0", got_q[0], 32'h1);
        chk("stall_w1", got_q[1], 32'h2);
        chk("stall_w2", got_q[2], 32'h4);

        // Zero-length and unaligned requests
        wc0 = we_cnt;
        rd_burst(32'hffffc003, 0, 100, 32'd0, 32'd0);
        chk("len0_no_bus", we_cnt - wc0, 0);
        rd_burst(32'hffffc003, 1, 100, 32'd0, 32'hffffc000);
        chk("unaligned_w0", got_q[0], 32'd0);

        wq = '{32'hdead0001, 32'hdead0002};
        we_log.delete();
        wr_burst(32'hfffffffc, 2, 0, 0);
        chk("wrap_addr0", we_log[0], 32'hfffffffc);
        chk("wrap_addr1", we_log[1], 32'h00000000);

        // Reset after the second of four beats
        wq = '{32'ha1, 32'ha2, 32'ha3, 32'ha4};
        wc0 = we_cnt;
        wr_burst(32'hffffc040, 4, 0, 2);
        chk("abort_beats", we_cnt - wc0, 2);
        rd_burst(32'hffffc040, 4, 100, 32'd0, 32'd0);
        chk("abort_rb0", got_q[0], 32'ha1);
        chk("abort_rb2", got_q[2], 32'd0);

        for (int j = 0; j < 64; j++) wq.push_back($urandom);
        wr_burst(32'hffffc000 + 32'd1200, 64, 20, 0);
        rd_burst(32'hffffc000 + 32'd1200, 64, 60, 32'd0, 32'd0);

        for (int t = 0; t < 30; t++) begin
            base = 32'hffffc000 + 32'(4 * $urandom_range(128, 950)) + 32'($urandom_range(0, 3));
            len  = $urandom_range(0, 16);
            if ($urandom_range(0, 1) == 1) begin
                for (int j = 0; j < len; j++) wq.push_back($urandom);
                wr_burst(base, len, $urandom_range(0, 60), 0);
            end else begin
                rd_burst(base, len, $urandom_range(30, 100), 32'd0, 32'd0);
            end
        end

        summary();
        $finish;
    end

endmodule
